// File: rtl/packet_concat_arbiter.sv
// Round-robin arbiter that stamps the winning port's fields into a unified-cache
// packet and buffers it in a two-entry queue with a valid/ack handshake.
module packet_concat_arbiter #(
  parameter int NUM_PORT = 4,
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 128,
  parameter int TYPE_LEN = 2,
  parameter int MASK_LEN = DATA_LEN / 8,
  parameter int PORT_LEN = 2,
  parameter bit CLEAR_READ_MASK = 1'b1,
  localparam int PACKET_LEN = ADDR_LEN + DATA_LEN + TYPE_LEN + MASK_LEN + PORT_LEN + 3
) (
  input  logic                         clk_in,
  input  logic                         reset_in,
  input  logic [NUM_PORT-1:0]          request_valid_in,
  output logic [NUM_PORT-1:0]          request_ack_out,
  input  logic [NUM_PORT*ADDR_LEN-1:0] addr_in,
  input  logic [NUM_PORT*DATA_LEN-1:0] data_in,
  input  logic [NUM_PORT*TYPE_LEN-1:0] type_in,
  input  logic [NUM_PORT*MASK_LEN-1:0] write_mask_in,
  input  logic [NUM_PORT-1:0]          is_write_in,
  input  logic [NUM_PORT-1:0]          cacheable_in,
  output logic [PACKET_LEN-1:0]        packet_out,
  output logic                         packet_valid_out,
  input  logic                         packet_ack_in,
  output logic                         busy_out
);

  localparam int PTR_W = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;

  logic [ADDR_LEN-1:0]   addr_arr [NUM_PORT];
  logic [DATA_LEN-1:0]   data_arr [NUM_PORT];
  logic [TYPE_LEN-1:0]   type_arr [NUM_PORT];
  logic [MASK_LEN-1:0]   mask_arr [NUM_PORT];

  logic [1:0]            count_q, count_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PACKET_LEN-1:0] entry_q [2];
  logic [PACKET_LEN-1:0] entry_d [2];

  logic                  win_found;
  logic [PTR_W-1:0]      win_idx;
  int                    cand;
  logic                  pop, push_ok, push;
  logic [PACKET_LEN-1:0] new_pkt;

  // Read packets carry no meaningful byte mask, so it can be zeroed per port up front.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORT; gi++) begin : g_unpack
      assign addr_arr[gi] = addr_in[gi*ADDR_LEN +: ADDR_LEN];
      assign data_arr[gi] = data_in[gi*DATA_LEN +: DATA_LEN];
      assign type_arr[gi] = type_in[gi*TYPE_LEN +: TYPE_LEN];
      assign mask_arr[gi] = (CLEAR_READ_MASK && !is_write_in[gi]) ? '0
                          : write_mask_in[gi*MASK_LEN +: MASK_LEN];
    end
  endgenerate

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_PORT; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_PORT) cand = cand - NUM_PORT;
      if (!win_found && request_valid_in[PTR_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(cand);
      end
    end
  end

  assign pop     = (count_q != 2'd0) && packet_ack_in;
  assign push_ok = (count_q != 2'd2) || pop;
  // Gating with reset_in keeps acks low while reset is held, not just after the edge.
  assign push    = win_found && push_ok && reset_in;

  always_comb begin
    request_ack_out = '0;
    if (push) request_ack_out[win_idx] = 1'b1;
  end

  assign new_pkt = {cacheable_in[win_idx], is_write_in[win_idx], 1'b1, PORT_LEN'(win_idx),
                    mask_arr[win_idx], type_arr[win_idx], data_arr[win_idx], addr_arr[win_idx]};

  always_comb begin
    entry_d = entry_q;
    count_d = count_q;
    case ({push, pop})
      2'b01: begin
        entry_d[0] = entry_q[1];
        entry_d[1] = '0;
        count_d    = count_q - 2'd1;
      end
      2'b10: begin
        if (count_q == 2'd0) entry_d[0] = new_pkt;
        else                 entry_d[1] = new_pkt;
        count_d = count_q + 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          entry_d[0] = new_pkt;
        end else begin
          entry_d[0] = entry_q[1];
          entry_d[1] = new_pkt;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (push) rr_ptr_d = (win_idx == PTR_W'(NUM_PORT - 1)) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      count_q    <= '0;
      rr_ptr_q   <= '0;
      entry_q[0] <= '0;
      entry_q[1] <= '0;
    end else begin
      count_q    <= count_d;
      rr_ptr_q   <= rr_ptr_d;
      entry_q[0] <= entry_d[0];
      entry_q[1] <= entry_d[1];
    end
  end

  assign packet_valid_out = (count_q != 2'd0);
  assign packet_out       = packet_valid_out ? entry_q[0] : '0;
  assign busy_out         = (count_q == 2'd2);

endmodule

// File: tb/tb_packet_concat_arbiter.sv
// Directed bench for packet_concat_arbiter: two instances (read-mask clearing on/off)
// share stimulus; a scoreboard monitor checks every popped packet.
module tb_packet_concat_arbiter;
  localparam int NP  = 4;
  localparam int AL  = 32;
  localparam int DL  = 128;
  localparam int TL  = 2;
  localparam int ML  = 16;
  localparam int PL  = 2;
  localparam int PKL = AL + DL + TL + ML + PL + 3;

  logic clk_in = 1'b0;
  logic reset_in = 1'b0;
  logic [NP-1:0] request_valid_in = '0;
  logic packet_ack_in = 1'b0;

  logic [AL-1:0] a   [NP];
  logic [DL-1:0] d   [NP];
  logic [TL-1:0] ty  [NP];
  logic [ML-1:0] msk [NP];
  logic [NP-1:0] wr, cach;

  logic [NP*AL-1:0] addr_in;
  logic [NP*DL-1:0] data_in;
  logic [NP*TL-1:0] type_in;
  logic [NP*ML-1:0] write_mask_in;

  assign addr_in       = {a[3], a[2], a[1], a[0]};
  assign data_in       = {d[3], d[2], d[1], d[0]};
  assign type_in       = {ty[3], ty[2], ty[1], ty[0]};
  assign write_mask_in = {msk[3], msk[2], msk[1], msk[0]};

  logic [NP-1:0]  ack1, ack0;
  logic [PKL-1:0] pkt1, pkt0;
  logic           pv1, pv0, busy1, busy0;

  packet_concat_arbiter #(.CLEAR_READ_MASK(1'b1)) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .request_valid_in(request_valid_in), .request_ack_out(ack1),
    .addr_in(addr_in), .data_in(data_in), .type_in(type_in),
    .write_mask_in(write_mask_in), .is_write_in(wr), .cacheable_in(cach),
    .packet_out(pkt1), .packet_valid_out(pv1), .packet_ack_in(packet_ack_in),
    .busy_out(busy1)
  );

  packet_concat_arbiter #(.CLEAR_READ_MASK(1'b0)) dut_nc (
    .clk_in(clk_in), .reset_in(reset_in),
    .request_valid_in(request_valid_in), .request_ack_out(ack0),
    .addr_in(addr_in), .data_in(data_in), .type_in(type_in),
    .write_mask_in(write_mask_in), .is_write_in(wr), .cacheable_in(cach),
    .packet_out(pkt0), .packet_valid_out(pv0), .packet_ack_in(packet_ack_in),
    .busy_out(busy0)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  logic [PKL-1:0] q1 [$];
  logic [PKL-1:0] q0 [$];

  task automatic chk(input string nm, input logic [PKL-1:0] act, input logic [PKL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  function automatic logic [PKL-1:0] mk(input int p, input bit crm);
    logic [ML-1:0] m;
    m = (crm && !wr[p]) ? '0 : msk[p];
    return {cach[p], wr[p], 1'b1, PL'(p), m, ty[p], d[p], a[p]};
  endfunction

  // One clock cycle: check combinational acks plus head state at mid-cycle,
  // record expected packets for each predicted ack, return at posedge+1.
  task automatic cyc(input logic [NP-1:0] exp_ack, input logic exp_v, input logic exp_b,
                     input string nm);
    @(negedge clk_in);
    chk({nm, " ack"}, PKL'(ack1), PKL'(exp_ack));
    chk({nm, " ack_nc"}, PKL'(ack0), PKL'(exp_ack));
    chk({nm, " valid"}, PKL'(pv1), PKL'(exp_v));
    chk({nm, " busy"}, PKL'(busy1), PKL'(exp_b));
    for (int p = 0; p < NP; p++) begin
      if (exp_ack[p]) begin
        q1.push_back(mk(p, 1'b1));
        q0.push_back(mk(p, 1'b0));
      end
    end
    @(posedge clk_in);
    #1;
  endtask

  // Scoreboard monitor: every accepted head must match the next expected packet.
  initial begin
    forever begin
      @(negedge clk_in);
      if (pv1 && packet_ack_in) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL mon clr: unexpected packet %h, required none", pkt1);
        end else begin
          chk("mon clr pkt", pkt1, q1.pop_front());
        end
      end
      if (pv0 && packet_ack_in) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL mon keep: unexpected packet %h, required none", pkt0);
        end else begin
          chk("mon keep pkt", pkt0, q0.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout, required $finish");
    $fatal(1);
  end

  initial begin
    for (int p = 0; p < NP; p++) begin
      a[p]   = 32'h2000 + p;
      d[p]   = {4{32'hC0DE0000 + p}};
      ty[p]  = TL'(p);
      msk[p] = 16'h0F0F;
      wr[p]  = p[0];
      cach[p] = p[1];
    end
    // Reset held with a pending request: nothing may be acked or presented.
    request_valid_in = 4'b0010;
    #12;
    chk("rst valid", PKL'(pv1), '0);
    chk("rst busy", PKL'(busy1), '0);
    chk("rst ack", PKL'(ack1), '0);
    chk("rst pkt", pkt1, '0);
    @(posedge clk_in); #1;
    reset_in = 1'b1;

    // Round-robin with all ports requesting and the consumer always ready.
    request_valid_in = 4'hF;
    packet_ack_in = 1'b1;
    cyc(4'b0001, 1'b0, 1'b0, "rr0");
    cyc(4'b0010, 1'b1, 1'b0, "rr1");
    cyc(4'b0100, 1'b1, 1'b0, "rr2");
    cyc(4'b1000, 1'b1, 1'b0, "rr3");
    cyc(4'b0001, 1'b1, 1'b0, "rr4");
    request_valid_in = '0;
    cyc(4'b0000, 1'b1, 1'b0, "rr drain");
    chk("empty pkt", pkt1, '0);

    // Single write on port 1.
    a[1] = 32'h1000; d[1] = {16{8'hA5}}; ty[1] = 2'd1; msk[1] = 16'hFFFF;
    wr[1] = 1'b1; cach[1] = 1'b1;
    request_valid_in = 4'b0010;
    cyc(4'b0010, 1'b0, 1'b0, "wr");
    request_valid_in = '0;
    chk("wr pkt", pkt1, {1'b1, 1'b1, 1'b1, 2'd1, 16'hFFFF, 2'd1, {16{8'hA5}}, 32'h1000});
    cyc(4'b0000, 1'b1, 1'b0, "wr out");

    // Read on port 0: mask cleared in one instance, passed in the other.
    a[0] = 32'h3000; d[0] = 128'h1; ty[0] = 2'd0; msk[0] = 16'h00FF; wr[0] = 1'b0;
    request_valid_in = 4'b0001;
    cyc(4'b0001, 1'b0, 1'b0, "rd");
    request_valid_in = '0;
    chk("rd mask clr", PKL'(pkt1[177:162]), PKL'(16'h0000));
    chk("rd mask keep", PKL'(pkt0[177:162]), PKL'(16'h00FF));
    cyc(4'b0000, 1'b1, 1'b0, "rd out");

    // Port 3 alone brings the pointer back to 0.
    request_valid_in = 4'b1000;
    cyc(4'b1000, 1'b0, 1'b0, "align");
    request_valid_in = '0;
    cyc(4'b0000, 1'b1, 1'b0, "align out");

    // Backpressure with ports 0 and 3 requesting.
    packet_ack_in = 1'b0;
    request_valid_in = 4'b1001;
    cyc(4'b0001, 1'b0, 1'b0, "bp0");
    cyc(4'b1000, 1'b1, 1'b0, "bp1");
    cyc(4'b0000, 1'b1, 1'b1, "bp full0");
    cyc(4'b0000, 1'b1, 1'b1, "bp full1");
    packet_ack_in = 1'b1;
    cyc(4'b0001, 1'b1, 1'b1, "bp swap");
    packet_ack_in = 1'b0;
    chk("bp head port", PKL'(pkt1[179:178]), PKL'(2'd3));
    cyc(4'b0000, 1'b1, 1'b1, "bp hold");

    // Pointer hold: port 3 waits while full, then wins on the draining cycle.
    request_valid_in = 4'b1000;
    cyc(4'b0000, 1'b1, 1'b1, "ph0");
    cyc(4'b0000, 1'b1, 1'b1, "ph1");
    cyc(4'b0000, 1'b1, 1'b1, "ph2");
    packet_ack_in = 1'b1;
    cyc(4'b1000, 1'b1, 1'b1, "ph drain");
    request_valid_in = 4'b0111;
    cyc(4'b0001, 1'b1, 1'b1, "ph ptr0");
    packet_ack_in = 1'b0;
    request_valid_in = 4'b0100;

    // Mid-stream asynchronous reset with a full queue.
    #2;
    reset_in = 1'b0;
    q1.delete();
    q0.delete();
    #1;
    chk("mid rst valid", PKL'(pv1), '0);
    chk("mid rst busy", PKL'(busy1), '0);
    chk("mid rst ack", PKL'(ack1), '0);
    chk("mid rst pkt", pkt1, '0);
    @(posedge clk_in); #1;
    reset_in = 1'b1;
    cyc(4'b0100, 1'b0, 1'b0, "post rst");
    request_valid_in = '0;
    chk("post rst port", PKL'(pkt1[179:178]), PKL'(2'd2));
    packet_ack_in = 1'b1;
    cyc(4'b0000, 1'b1, 1'b0, "post out");
    cyc(4'b0000, 1'b0, 1'b0, "end");
    chk("sb clr empty", PKL'(q1.size()), '0);
    chk("sb keep empty", PKL'(q0.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
